// File: rtl/b_cache_wr_seq_if.sv
// Command/handshake and B-cache write bus between the EKF stage FSM, the write sequencer and the mapper/BRAM.
interface b_cache_wr_seq_if #(
    parameter int unsigned SEQ_CNT_DW = 10,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned TP_LEN_W   = 6
);
    logic                  start;
    logic [3:0]            op;
    logic [ADDR_W-1:0]     base_addr;
    logic [TP_LEN_W-1:0]   tp_len;
    logic                  abort;
    logic                  start_ack;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [3:0]            B_cache_in_sel;
    logic [SEQ_CNT_DW-1:0] seq_cnt_out;
    logic                  B_cache_wea;
    logic [ADDR_W-1:0]     B_cache_addra;

    // Stage FSM side: issues jobs, observes status and the write port.
    modport master (
        output start, op, base_addr, tp_len, abort,
        input  start_ack, busy, done, err, B_cache_in_sel, seq_cnt_out, B_cache_wea, B_cache_addra
    );

    // Sequencer side.
    modport slave (
        input  start, op, base_addr, tp_len, abort,
        output start_ack, busy, done, err, B_cache_in_sel, seq_cnt_out, B_cache_wea, B_cache_addra
    );
endinterface

// File: rtl/b_cache_wr_seq.sv
// B-cache write sequencer: runs one mapper job (sel/seq_cnt) and issues port-A writes aligned
// to the mapper's one-cycle registered data, then pulses done.
module b_cache_wr_seq #(
    parameter int unsigned SEQ_CNT_DW = 10,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned TP_LEN_W   = 6
) (
    input  logic clk,
    input  logic sys_rst_n,
    b_cache_wr_seq_if.slave bus
);
    localparam logic [3:0] OP_IDLE      = 4'b0000;
    localparam logic [3:0] OP_RSVD      = 4'b1000;
    localparam logic [3:0] OP_TRANSPOSE = 4'b1001;
    localparam logic [3:0] OP_INV       = 4'b1010;
    localparam logic [3:0] OP_CHI       = 4'b1011;
    localparam logic [3:0] OP_NL_PRD    = 4'b1100;
    localparam logic [3:0] OP_NL_ASSOC  = 4'b1101;
    localparam logic [3:0] OP_NL_NEW    = 4'b1110;
    localparam logic [3:0] OP_NL_UPD    = 4'b1111;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                state, state_d;
    logic [3:0]            op_q, op_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [TP_LEN_W-1:0]   len_q, len_d;
    logic [SEQ_CNT_DW-1:0] seq_q, seq_d;
    logic [3:0]            sel_q, sel_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wea_q, wea_d;
    logic [ADDR_W-1:0]     addra_q, addra_d;
    logic [SEQ_CNT_DW-1:0] first_c, last_c;
    logic                  op_ok_c, req_c, accept_c, reject_c;

    // Write window of the latched job; INV/CHI count through the mapper's compute cycles first.
    always_comb begin
        first_c = SEQ_CNT_DW'(1);
        last_c  = SEQ_CNT_DW'(1);
        case (op_q)
            OP_NL_PRD:               last_c = SEQ_CNT_DW'(5);
            OP_NL_NEW:               last_c = SEQ_CNT_DW'(6);
            OP_NL_ASSOC, OP_NL_UPD:  last_c = SEQ_CNT_DW'(7);
            OP_INV:      begin first_c = SEQ_CNT_DW'(7);  last_c = SEQ_CNT_DW'(9);  end
            OP_CHI:      begin first_c = SEQ_CNT_DW'(10); last_c = SEQ_CNT_DW'(11); end
            OP_TRANSPOSE:            last_c = SEQ_CNT_DW'(len_q);
            default: ;
        endcase
    end

    // Acceptance is decided combinationally so start_ack/err land in the request cycle itself.
    always_comb begin
        op_ok_c  = bus.op[3] && (bus.op != OP_RSVD);
        req_c    = (state == IDLE) && bus.start && !bus.abort;
        accept_c = req_c && op_ok_c && ((bus.op != OP_TRANSPOSE) || (bus.tp_len != '0));
        reject_c = req_c && !accept_c;
    end

    always_comb begin
        state_d = state;
        op_d    = op_q;
        base_d  = base_q;
        len_d   = len_q;
        seq_d   = '0;
        sel_d   = OP_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        wea_d   = 1'b0;
        addra_d = '0;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    state_d = RUN;
                    op_d    = bus.op;
                    base_d  = bus.base_addr;
                    len_d   = bus.tp_len;
                    seq_d   = SEQ_CNT_DW'(1);
                    sel_d   = bus.op;
                    busy_d  = 1'b1;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    busy_d = 1'b1;
                    sel_d  = op_q;
                    if (seq_q == last_c) begin
                        state_d = DRAIN;
                    end else begin
                        seq_d = seq_q + SEQ_CNT_DW'(1);
                    end
                    // Mapper data for this count is registered, so the write goes out next cycle.
                    if (seq_q >= first_c) begin
                        wea_d   = 1'b1;
                        addra_d = base_q + ADDR_W'(seq_q - first_c);
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
                done_d  = !bus.abort;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            op_q    <= '0;
            base_q  <= '0;
            len_q   <= '0;
            seq_q   <= '0;
            sel_q   <= OP_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wea_q   <= 1'b0;
            addra_q <= '0;
        end else begin
            state   <= state_d;
            op_q    <= op_d;
            base_q  <= base_d;
            len_q   <= len_d;
            seq_q   <= seq_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
        end
    end

    assign bus.start_ack      = accept_c;
    assign bus.err            = reject_c;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.B_cache_in_sel = sel_q;
    assign bus.seq_cnt_out    = seq_q;
    assign bus.B_cache_wea    = wea_q;
    assign bus.B_cache_addra  = addra_q;
endmodule
